sys_bus: RTL

SYS_BUS -- requirements
Module: sys_bus

---
 rtl/sys_bus_pkg.sv | 18 +
 rtl/sys_bus_decoder.sv | 32 +++
 rtl/sys_bus.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sys_bus_pkg.sv
// sys_bus shared definitions: FSM state encoding and default region map.
// Used by sys_bus and sb_decoder.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } sb_state_t;

  localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_ROM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_RAM_MASK = 32'hFFFF_0000;
  localparam int          DEF_TIMEOUT  = 16;

endpackage

// File: rtl/sys_bus_decoder.sv
// sb_decoder: combinational region decode for sys_bus.
// ROM wins on overlap; ROM writes, misaligned or unmapped addresses error.
module sb_decoder
  import sys_bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] ROM_MASK = DEF_ROM_MASK,
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] RAM_MASK = DEF_RAM_MASK
) (
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        sel_rom,
  output logic        sel_ram,
  output logic        dec_err
);

  logic w_rom_hit;
  logic w_ram_hit;
  logic w_misal;

  assign w_rom_hit = (addr & ROM_MASK) == ROM_BASE;
  assign w_ram_hit = !w_rom_hit && ((addr & RAM_MASK) == RAM_BASE);
  assign w_misal   = |addr[1:0];

  assign dec_err = w_misal
                 | (!w_rom_hit && !w_ram_hit)
                 | (w_rom_hit && wr);
  assign sel_rom = w_rom_hit && !dec_err;
  assign sel_ram = w_ram_hit && !dec_err;

endmodule

// File: rtl/sys_bus.sv
// sys_bus: single-outstanding bridge from one master to ROM/RAM slaves.
// Optional WAIT timeout enabled by defining SB_TIMEOUT_EN.
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = DEF_ROM_BASE,
  parameter logic [31:0] ROM_MASK       = DEF_ROM_MASK,
  parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE,
  parameter logic [31:0] RAM_MASK       = DEF_RAM_MASK,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_sb_addr,
  input  logic        cpu_sb_req,
  input  logic        cpu_sb_wr,
  input  logic [31:0] cpu_sb_wdata,
  output logic        cpu_sb_gnt,
  output logic [31:0] cpu_sb_read_data,
  output logic        cpu_sb_read_valid,
  output logic        cpu_sb_err,
  output logic [31:0] sb_rom_addr,
  output logic        sb_rom_req,
  input  logic [31:0] sb_rom_read_data,
  input  logic        sb_rom_read_valid,
  output logic [31:0] sb_ram_addr,
  output logic        sb_ram_req,
  output logic        sb_ram_wr,
  output logic [31:0] sb_ram_wdata,
  input  logic [31:0] sb_ram_read_data,
  input  logic        sb_ram_read_valid
);

  sb_state_t   r_state;
  sb_state_t   w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_wr;
  logic        r_sel_rom;
  logic        r_sel_ram;
  logic        r_gnt;
  logic        r_rvalid;
  logic        w_sel_rom;
  logic        w_sel_ram;
  logic        w_dec_err;
  logic        w_accept;
  logic        w_resp;
  logic        w_tout;
  logic        w_slv_valid;
  logic [31:0] w_slv_data;

  sb_decoder #(
    .ROM_BASE (ROM_BASE),
    .ROM_MASK (ROM_MASK),
    .RAM_BASE (RAM_BASE),
    .RAM_MASK (RAM_MASK)
  ) u_dec (
    .addr    (cpu_sb_addr),
    .wr      (cpu_sb_wr),
    .sel_rom (w_sel_rom),
    .sel_ram (w_sel_ram),
    .dec_err (w_dec_err)
  );

  assign w_slv_valid = (r_sel_rom && sb_rom_read_valid)
                    || (r_sel_ram && sb_ram_read_valid);
  assign w_slv_data  = r_sel_rom ? sb_rom_read_data
                                 : sb_ram_read_data;

`ifdef SB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt;

  // Wait-cycle counter, restarted each time WAIT is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_tcnt <= '0;
    else if (r_state == S_REQ) r_tcnt <= '0;
    else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 1'b1;
  end
`endif

  // Next-state decode and single-cycle event strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_resp   = 1'b0;
    w_tout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_sb_req) begin
          w_accept = 1'b1;
          w_next   = w_dec_err ? S_ERR : S_REQ;
        end
      end
      S_REQ: w_next = S_WAIT;
      S_WAIT: begin
        if (w_slv_valid) begin
          w_resp = 1'b1;
          w_next = S_IDLE;
        end
`ifdef SB_TIMEOUT_EN
        else if (r_tcnt == T_LAST) begin
          w_tout = 1'b1;
          w_next = S_ERR;
        end
`endif
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch and registered master response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_sel_rom <= 1'b0;
      r_sel_ram <= 1'b0;
      r_gnt     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state  <= w_next;
      r_gnt    <= w_accept;
      r_rvalid <= w_resp;
      if (w_accept) begin
        r_addr    <= cpu_sb_addr;
        r_wdata   <= cpu_sb_wdata;
        r_wr      <= cpu_sb_wr;
        r_sel_rom <= w_sel_rom;
        r_sel_ram <= w_sel_ram;
      end
      if (w_resp)
        r_rdata <= r_wr ? 32'h0 : w_slv_data;
      else if ((w_accept && w_dec_err) || w_tout)
        r_rdata <= 32'h0;
    end
  end

  assign cpu_sb_gnt        = r_gnt;
  assign cpu_sb_err        = (r_state == S_ERR);
  assign cpu_sb_read_valid = r_rvalid;
  assign cpu_sb_read_data  = r_rdata;

  assign sb_rom_req   = (r_state == S_REQ) && r_sel_rom;
  assign sb_ram_req   = (r_state == S_REQ) && r_sel_ram;
  assign sb_rom_addr  = r_sel_rom ? (r_addr & ~ROM_MASK) : 32'h0;
  assign sb_ram_addr  = r_sel_ram ? (r_addr & ~RAM_MASK) : 32'h0;
  assign sb_ram_wr    = r_sel_ram && r_wr;
  assign sb_ram_wdata = r_sel_ram ? r_wdata : 32'h0;

endmodule
